// File: rtl/fifo_read_arbiter_if.sv
// Bus between the FIFO read port, its consumers and the read-port arbiter.
// The arbiter takes the slave side; the consumers/FIFO model take the master side.
interface fifo_read_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]    REQ;
    logic                  EMPTY_flag;
    logic [DATA_WIDTH-1:0] RDATA;
    logic                  Rinc;
    logic [NUM_REQ-1:0]    GNT;
    logic [DATA_WIDTH-1:0] RD_DATA;
    logic [NUM_REQ-1:0]    RD_VALID;
    logic                  BUSY;

    modport slave (
        input  REQ,
        input  EMPTY_flag,
        input  RDATA,
        output Rinc,
        output GNT,
        output RD_DATA,
        output RD_VALID,
        output BUSY
    );

    modport master (
        output REQ,
        output EMPTY_flag,
        output RDATA,
        input  Rinc,
        input  GNT,
        input  RD_DATA,
        input  RD_VALID,
        input  BUSY
    );
endinterface

// File: rtl/fifo_read_arbiter.sv
// Round-robin arbiter sharing one FIFO read port among NUM_REQ consumers,
// granting bounded bursts and returning popped data one cycle later.
module fifo_read_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    parameter int STALL_MAX  = 8
) (
    input  logic                 R_CLK,
    input  logic                 RST,
    fifo_read_arbiter_if.slave   bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int BC_W  = $clog2(MAX_BURST) + 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t                state_q, state_d;
    logic [NUM_REQ-1:0]    gnt_q, gnt_d;
    logic [NUM_REQ-1:0]    rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [BC_W-1:0]       burst_cnt_q, burst_cnt_d;
    logic [7:0]            stall_cnt_q, stall_cnt_d;
    logic [IDX_W-1:0]      last_winner_q, last_winner_d;

    logic [IDX_W-1:0]      winner;
    logic                  found;
    int                    idx;
    logic [NUM_REQ-1:0]    winner_onehot;
    logic [NUM_REQ-1:0]    owner_hit;
    logic                  owner_req;
    logic                  rinc;

    // Search upward starting just after the previous winner, wrapping modulo NUM_REQ.
    always_comb begin
        winner = last_winner_q;
        found  = 1'b0;
        idx    = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = int'(last_winner_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && bus.REQ[idx]) begin
                found  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign winner_onehot[gi] = (winner == IDX_W'(gi));
        assign owner_hit[gi]     = gnt_q[gi] & bus.REQ[gi];
    end

    assign owner_req = |owner_hit;
    assign rinc      = (state_q == BURST) && owner_req && !bus.EMPTY_flag && !RST;

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        burst_cnt_d   = burst_cnt_q;
        stall_cnt_d   = stall_cnt_q;
        last_winner_d = last_winner_q;
        rd_valid_d    = '0;
        rd_data_d     = rd_data_q;

        if (rinc) begin
            rd_valid_d = gnt_q;
            rd_data_d  = bus.RDATA;
        end

        if (state_q == IDLE) begin
            if (found) begin
                state_d       = BURST;
                gnt_d         = winner_onehot;
                last_winner_d = winner;
                burst_cnt_d   = '0;
                stall_cnt_d   = '0;
            end
        end else begin
            if (!owner_req) begin
                state_d = IDLE;
                gnt_d   = '0;
            end else if (rinc) begin
                burst_cnt_d = burst_cnt_q + 1'b1;
                stall_cnt_d = '0;
                if (burst_cnt_q == BC_W'(MAX_BURST - 1)) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end else begin
                // Owner still wants data but the FIFO is empty: give up after STALL_MAX cycles.
                stall_cnt_d = stall_cnt_q + 8'd1;
                if (stall_cnt_q == 8'(STALL_MAX - 1)) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
        end
    end

    always_ff @(posedge R_CLK) begin
        if (RST) begin
            state_q       <= IDLE;
            gnt_q         <= '0;
            rd_valid_q    <= '0;
            rd_data_q     <= '0;
            burst_cnt_q   <= '0;
            stall_cnt_q   <= '0;
            last_winner_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
            burst_cnt_q   <= burst_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            last_winner_q <= last_winner_d;
        end
    end

    assign bus.Rinc     = rinc;
    assign bus.GNT      = gnt_q;
    assign bus.RD_DATA  = rd_data_q;
    assign bus.RD_VALID = rd_valid_q;
    assign bus.BUSY     = (state_q == BURST);

endmodule

// File: doc/fifo_read_arbiter.md
Name: fifo_read_arbiter

Overview:
Round-robin arbiter sharing the single read port of the asynchronous FIFO among NUM_REQ read-domain consumers. Grants one requester at a time for a bounded burst and drives the FIFO read-increment (Rinc) while honouring EMPTY_flag. Registers the FIFO read data back to the granted consumer with a per-requester valid. Sits entirely in the FIFO read clock domain, between the consumers and the FIFO read pointer/memory.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, FIFO read data width
MAX_BURST, 4, max reads per grant (1..16)
STALL_MAX, 8, consecutive empty cycles tolerated before grant is released (1..255)

Ports:
R_CLK  input  1  read-domain clock
RST  input  1  synchronous reset, active-high
REQ  input  NUM_REQ  per-requester read request, level
EMPTY_flag  input  1  FIFO empty status (read domain)
RDATA  input  DATA_WIDTH  FIFO data at current read address, combinational from FIFO
Rinc  output  1  FIFO read increment, one pop per high cycle
GNT  output  NUM_REQ  registered one-hot grant
RD_DATA  output  DATA_WIDTH  registered read data
RD_VALID  output  NUM_REQ  one-hot, RD_DATA valid for that requester
BUSY  output  1  high in BURST state

Behaviour:
- Reset (RST=1 at R_CLK edge): state IDLE, GNT=0, RD_VALID=0, RD_DATA=0, burst_cnt=0, stall_cnt=0, last_winner=NUM_REQ-1 (requester 0 has first priority). Rinc forced 0 while RST=1.
- States: IDLE, BURST.
- IDLE: Rinc=0, BUSY=0. If REQ!=0, winner = first set bit searching upward from last_winner+1 mod NUM_REQ; next edge: GNT=onehot(winner), last_winner=winner, burst_cnt=0, stall_cnt=0, go BURST. REQ=0: stay.
- BURST: owner = bit set in GNT. Rinc = REQ[owner] & ~EMPTY_flag (combinational). BUSY=1.
  - Rinc=1: burst_cnt+1; stall_cnt=0; if burst_cnt==MAX_BURST-1 -> IDLE, GNT=0 at next edge.
  - REQ[owner]=0: Rinc=0, -> IDLE next edge (release; no pop that cycle).
  - REQ[owner]=1 & EMPTY_flag=1: no pop; stall_cnt+1; if stall_cnt==STALL_MAX-1 -> IDLE (release).
- Return path, latency 1: on edge where Rinc=1, RD_DATA<=RDATA, RD_VALID<=GNT; otherwise RD_VALID<=0, RD_DATA holds.
- No IDLE->BURST bypass: minimum one IDLE cycle between grants; new winner arbitrated in that IDLE cycle, so back-to-back grants to different requesters are 1 cycle apart.
- Requests asserted in IDLE by several requesters: exactly one granted; others wait. Rotation guarantees each active requester is granted within NUM_REQ grants.
- Changes in non-owner REQ bits during BURST are ignored.
- EMPTY_flag rising on the last-burst cycle: no pop; burst not complete; stall counting applies.
- Reset mid-burst: Rinc drops in the reset cycle; all state cleared at that edge; in-flight RD_VALID cleared.
- Counter widths: burst_cnt ceil(log2(MAX_BURST))+1 bits, stall_cnt 8 bits; no wrap occurs as exits precede overflow.
- GNT is always zero or one-hot; RD_VALID is a subset of the previous cycle's GNT.

Test Plan:
1. Reset with REQ=4'b1111 held -> all outputs 0 during RST; first edge after release GNT=0001, BUSY=1; Rinc=1 for 4 cycles; RD_VALID=0001 four times with RD_DATA = FIFO words 0..3; then IDLE one cycle, GNT=0010.
2. REQ=4'b1010, FIFO non-empty, MAX_BURST=4 -> grants alternate 0010, 1000, 0010; each burst exactly 4 pops; no grant to 0001/0100.
3. Owner 0 granted, FIFO holds 2 words -> 2 pops, EMPTY_flag=1 for 8 cycles -> Rinc stays 0, grant released after 8th stalled cycle, BUSY=0.
4. Owner drops REQ[0] after 2 pops -> Rinc=0 that cycle, IDLE next edge, exactly 2 RD_VALID pulses, FIFO read pointer advanced by 2.
5. RST asserted during third pop of a burst -> Rinc=0 in reset cycle, GNT=RD_VALID=0 next edge, read pointer advanced exactly 2; after release, requester 0 regains priority.
6. EMPTY_flag toggling every cycle with REQ[2] held -> Rinc only in non-empty cycles, burst ends after 4 total pops, RD_DATA matches FIFO order, no RD_VALID in empty cycles.
